// File: rtl/btn_conditioner.sv
// Push-button front end: 2-flop synchroniser, sample-tick divider, per-button debounce FSM.
// Optional macro BTN_CONDITIONER_ONEHOT_EN limits btn_press to the lowest qualifying button.
module btn_conditioner #(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned DEB_SAMPLES = 4,
  parameter int unsigned NBTN        = 5
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_raw,
  output logic            tick,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release
);

  localparam int unsigned CW      = 23;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [3:0]  DEB_N   = 4'(DEB_SAMPLES);
  localparam logic        DEB_ONE = (DEB_SAMPLES == 1);

  // Bit 1 of the state encoding is the debounced level.
  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic [NBTN-1:0] sync_q1;
  logic [NBTN-1:0] btn_sync;
  logic [CW-1:0]   cnt;
  logic            s_int_c;
  logic [1:0]      state     [NBTN];
  logic [1:0]      state_nxt [NBTN];
  logic [3:0]      scnt      [NBTN];
  logic [3:0]      scnt_nxt  [NBTN];
  logic [NBTN-1:0] level_nxt_c;
  logic [NBTN-1:0] rise_c;
  logic [NBTN-1:0] fall_c;
  logic [NBTN-1:0] press_c;

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync_q1  <= '0;
      btn_sync <= '0;
    end else begin
      sync_q1  <= btn_raw;
      btn_sync <= sync_q1;
    end
  end

  // Sample divider.
  assign s_int_c = (cnt == CNT_MAX);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (s_int_c) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

  // Debounce state registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NBTN; i++) begin
        state[i] <= IDLE;
        scnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        state[i] <= state_nxt[i];
        scnt[i]  <= scnt_nxt[i];
      end
    end
  end

  // Debounce next-state logic; only advances on the sample strobe.
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      state_nxt[i] = state[i];
      scnt_nxt[i]  = scnt[i];
      if (s_int_c) begin
        case (state[i])
          IDLE: begin
            if (btn_sync[i]) begin
              if (DEB_ONE) begin
                state_nxt[i] = HELD;
              end else begin
                state_nxt[i] = PRESS_WAIT;
                scnt_nxt[i]  = 4'd1;
              end
            end
          end
          PRESS_WAIT: begin
            if (!btn_sync[i]) begin
              state_nxt[i] = IDLE;
              scnt_nxt[i]  = '0;
            end else if (scnt[i] + 4'd1 == DEB_N) begin
              state_nxt[i] = HELD;
              scnt_nxt[i]  = '0;
            end else if (scnt[i] != 4'hF) begin
              scnt_nxt[i]  = scnt[i] + 4'd1;
            end
          end
          HELD: begin
            if (!btn_sync[i]) begin
              if (DEB_ONE) begin
                state_nxt[i] = IDLE;
              end else begin
                state_nxt[i] = RELEASE_WAIT;
                scnt_nxt[i]  = 4'd1;
              end
            end
          end
          default: begin
            if (btn_sync[i]) begin
              state_nxt[i] = HELD;
              scnt_nxt[i]  = '0;
            end else if (scnt[i] + 4'd1 == DEB_N) begin
              state_nxt[i] = IDLE;
              scnt_nxt[i]  = '0;
            end else if (scnt[i] != 4'hF) begin
              scnt_nxt[i]  = scnt[i] + 4'd1;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NBTN; i++) level_nxt_c[i] = state_nxt[i][1];
  end

  assign rise_c = level_nxt_c & ~btn_level;
  assign fall_c = ~level_nxt_c & btn_level;

`ifdef BTN_CONDITIONER_ONEHOT_EN
  // Keep only the lowest set bit; the other presses are dropped.
  assign press_c = rise_c & (~rise_c + NBTN'(1));
`else
  assign press_c = rise_c;
`endif

  // Registered outputs; level and pulses all land in the tick cycle.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      tick        <= 1'b0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      tick        <= s_int_c;
      btn_level   <= level_nxt_c;
      btn_press   <= press_c;
      btn_release <= fall_c;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with TICK_DIV=4, DEB_SAMPLES=3, NBTN=5.
module tb_btn_conditioner;

  localparam int unsigned TD  = 4;
  localparam int unsigned DEB = 3;
  localparam int unsigned NB  = 5;

`ifdef BTN_CONDITIONER_ONEHOT_EN
  localparam logic [4:0] EXP_DUAL_PRESS = 5'b00010;
`else
  localparam logic [4:0] EXP_DUAL_PRESS = 5'b10010;
`endif

  typedef struct {
    logic [4:0] raw;
    logic [4:0] level;
    logic [4:0] press;
    logic [4:0] rel;
  } vec_t;

  logic          CLK;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic          tick;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] last_level;
  vec_t vecs [64];
  int   nvec = 0;

  btn_conditioner #(.TICK_DIV(TD), .DEB_SAMPLES(DEB), .NBTN(NB)) dut (
    .CLK(CLK), .reset(reset), .btn_raw(btn_raw), .tick(tick),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [4:0] raw, input logic [4:0] lvl,
                     input logic [4:0] prs, input logic [4:0] rel);
    vecs[nvec].raw   = raw;
    vecs[nvec].level = lvl;
    vecs[nvec].press = prs;
    vecs[nvec].rel   = rel;
    nvec++;
  endtask

  // Advance to the next tick cycle (sampled on negedge); outside ticks nothing may move.
  task automatic next_tick(output int ncyc);
    ncyc = 0;
    for (int n = 1; n <= 3 * TD; n++) begin
      @(negedge CLK);
      if (tick === 1'b1) begin
        ncyc = n;
        last_level = btn_level;
        return;
      end
      check("quiet_pulses", {27'd0, btn_press | btn_release}, 32'd0);
      check("quiet_level", {27'd0, btn_level}, {27'd0, last_level});
    end
    check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_tick(input string name, input logic [4:0] lvl,
                             input logic [4:0] prs, input logic [4:0] rel);
    int n;
    next_tick(n);
    check({name, "_period"}, n, TD);
    check({name, "_level"}, {27'd0, btn_level}, {27'd0, lvl});
    check({name, "_press"}, {27'd0, btn_press}, {27'd0, prs});
    check({name, "_release"}, {27'd0, btn_release}, {27'd0, rel});
  endtask

  initial begin
    int n;
    reset      = 1'b0;
    btn_raw    = '0;
    last_level = '0;

    // Button 0 clean press, hold, release.
    add(5'b00001, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00001, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00001, 5'b00001, 5'b00001, 5'b00000);
    add(5'b00001, 5'b00001, 5'b00000, 5'b00000);
    add(5'b00001, 5'b00001, 5'b00000, 5'b00000);
    add(5'b00000, 5'b00001, 5'b00000, 5'b00000);
    add(5'b00000, 5'b00001, 5'b00000, 5'b00000);
    add(5'b00000, 5'b00000, 5'b00000, 5'b00001);
    add(5'b00000, 5'b00000, 5'b00000, 5'b00000);
    // Button 2 bounce 1,1,0,1,1,0 never qualifies.
    add(5'b00100, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00100, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00000, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00100, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00100, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00000, 5'b00000, 5'b00000, 5'b00000);
    // Buttons 1 and 4 together, a one-sample dropout on 4, then release.
    add(5'b10010, 5'b00000, 5'b00000, 5'b00000);
    add(5'b10010, 5'b00000, 5'b00000, 5'b00000);
    add(5'b10010, 5'b10010, EXP_DUAL_PRESS, 5'b00000);
    add(5'b10010, 5'b10010, 5'b00000, 5'b00000);
    add(5'b00010, 5'b10010, 5'b00000, 5'b00000);
    add(5'b10010, 5'b10010, 5'b00000, 5'b00000);
    add(5'b00000, 5'b10010, 5'b00000, 5'b00000);
    add(5'b00000, 5'b10010, 5'b00000, 5'b00000);
    add(5'b00000, 5'b00000, 5'b00000, 5'b10010);
    add(5'b00000, 5'b00000, 5'b00000, 5'b00000);

    repeat (3) @(negedge CLK);
    check("reset_tick", {31'd0, tick}, 32'd0);
    check("reset_outs", {17'd0, btn_level, btn_press, btn_release}, 32'd0);
    reset = 1'b1;

    // First tick lands TICK_DIV edges after release, then every TICK_DIV.
    next_tick(n);
    check("first_tick", n, TD);
    check("first_tick_outs", {17'd0, btn_level, btn_press, btn_release}, 32'd0);
    next_tick(n);
    check("second_tick", n, TD);

    for (int j = 0; j < nvec; j++) begin
      btn_raw = vecs[j].raw;
      expect_tick($sformatf("vec%0d", j), vecs[j].level, vecs[j].press, vecs[j].rel);
    end

    // Reset mid-debounce with button 3 still held.
    btn_raw = 5'b01000;
    expect_tick("pre_rst1", 5'b00000, 5'b00000, 5'b00000);
    expect_tick("pre_rst2", 5'b00000, 5'b00000, 5'b00000);
    reset = 1'b0;
    #1;
    check("midrst_outs", {16'd0, tick, btn_level, btn_press, btn_release}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    last_level = '0;
    expect_tick("post_rst1", 5'b00000, 5'b00000, 5'b00000);
    expect_tick("post_rst2", 5'b00000, 5'b00000, 5'b00000);
    expect_tick("post_rst3", 5'b01000, 5'b01000, 5'b00000);
    btn_raw = 5'b00000;
    expect_tick("rel3_1", 5'b01000, 5'b00000, 5'b00000);
    expect_tick("rel3_2", 5'b01000, 5'b00000, 5'b00000);
    expect_tick("rel3_3", 5'b00000, 5'b00000, 5'b01000);

    // Sub-cycle glitch between clock edges is never captured.
    @(posedge CLK);
    #2 btn_raw = 5'b00001;
    #2 btn_raw = 5'b00000;
    next_tick(n);
    check("glitch_t1", {17'd0, btn_level, btn_press, btn_release}, 32'd0);
    expect_tick("glitch_t2", 5'b00000, 5'b00000, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end stage that feeds the guess-number game controller.
- Takes the five raw push-buttons (I1..I4, enter), synchronises them to CLK, and generates the slow sample tick the controller runs on.
- Debounces each button against that tick.
- Delivers clean debounced levels plus one-tick press pulses aligned with the tick, so the controller needs no edge-lockout logic of its own.

Parameters:
- TICK_DIV, 100000: CLK cycles per sample tick; legal range 2..2^23-1.
- DEB_SAMPLES, 4: consecutive agreeing tick samples required to change a debounced level; legal range 1..15.
- NBTN, 5: number of buttons. Bit order is 0=I1, 1=I2, 2=I3, 3=I4, 4=enter.

Ports:
- CLK, input, 1: system clock; all state is rising-edge.
- reset, input, 1: asynchronous, active-low reset (reset==0 resets).
- btn_raw, input, NBTN: raw, asynchronous, bouncing button inputs; active-high.
- tick, output, 1: one-CLK-cycle pulse, once every TICK_DIV cycles.
- btn_level, output, NBTN: debounced button levels.
- btn_press, output, NBTN: one-CLK-cycle press pulse; only ever high in a cycle where tick is high.
- btn_release, output, NBTN: one-CLK-cycle release pulse; only ever high in a cycle where tick is high.

Behaviour:
- Reset (reset low, asynchronous):
  - Divider counter = 0, all FSMs = IDLE, sample counters = 0, synchroniser flops = 0.
  - tick, btn_level, btn_press, btn_release all = 0.
  - Deassertion is synchronous to CLK.
  - Reset mid-debounce discards the partial count; a held button must re-qualify over DEB_SAMPLES full ticks after release.
- Synchroniser: two flops per bit. btn_sync lags btn_raw by 2 CLK cycles. No combinational path from btn_raw to any output.
- Divider:
  - cnt counts 0..TICK_DIV-1 and wraps to 0.
  - Internal sample strobe s_int = (cnt == TICK_DIV-1).
  - Registered output tick is high in the cycle after s_int.
  - First tick after reset therefore appears at CLK cycle TICK_DIV+1 counted from the first edge after reset release. Period is exactly TICK_DIV thereafter.
- Per-button FSM: advances only on edges where s_int==1, sampling btn_sync. scnt is a 4-bit sample counter.
  - IDLE (level 0):
    - sample 1 and DEB_SAMPLES==1 -> HELD.
    - sample 1 otherwise -> PRESS_WAIT, scnt=1.
    - sample 0 -> stay.
  - PRESS_WAIT (level 0):
    - sample 1 -> scnt+1; when scnt+1 == DEB_SAMPLES -> HELD.
    - sample 0 -> IDLE, scnt=0.
  - HELD (level 1):
    - sample 0 and DEB_SAMPLES==1 -> IDLE.
    - sample 0 otherwise -> RELEASE_WAIT, scnt=1.
    - sample 1 -> stay.
  - RELEASE_WAIT (level 1):
    - sample 0 -> scnt+1; when scnt+1 == DEB_SAMPLES -> IDLE.
    - sample 1 -> HELD, scnt=0.
- Outputs:
  - btn_level is registered and changes in the same cycle tick is high.
  - btn_press[i] is high for exactly that one cycle when btn_level[i] goes 0->1.
  - btn_release[i] is high for exactly that one cycle when btn_level[i] goes 1->0.
  - All other cycles: press = release = 0.
- Latency: a clean press that is stable from before sample k yields btn_press on the tick following sample k+DEB_SAMPLES-1.
- Glitch rejection: any bounce shorter than DEB_SAMPLES consecutive samples produces no level change and no pulse.
- Simultaneous events: buttons are fully independent; several bits of btn_press may assert in the same cycle.
- Holding a button produces one press only; there is no auto-repeat.
- scnt saturates and never wraps.

Optional Feature:
- Macro: BTN_CONDITIONER_ONEHOT_EN.
- Defined:
  - btn_press is guaranteed at most one-hot.
  - If several buttons qualify in the same tick, only the lowest index is reported.
  - The others still update btn_level but their press pulses are dropped, not deferred.
  - btn_release is unaffected.
- Undefined: btn_press is reported per bit independently, as above.

Test Plan (bench uses TICK_DIV=4, DEB_SAMPLES=3, NBTN=5):
- Reset low for 3 cycles then release, no buttons -> all outputs 0; tick high at cycle 5 and every 4 cycles after.
- btn_raw[0] held 1 from before sample 1 -> btn_press=5'b00001 and btn_level[0]=1 in the tick cycle after sample 3; no further press while held; release held 0 -> btn_release[0] pulses after 3 zero samples.
- btn_raw[2] pattern 1,1,0,1,1,0 across consecutive samples -> no btn_press, btn_level stays 0.
- btn_raw[1] and btn_raw[4] both rise before the same sample -> btn_press=5'b10010 in one tick cycle; with BTN_CONDITIONER_ONEHOT_EN -> 5'b00010, and btn_level=5'b10010.
- btn_raw[3] high for 2 samples, reset pulsed low, button still held -> all outputs 0 immediately; btn_press[3] after 3 samples post-reset.
- Raw toggle narrower than 1 CLK, between ticks -> no output change; no output bit toggles except in tick cycles.
